// File: rtl/axil_mem_bist_if.sv
// AXI4-Lite channel bundle between the BIST sequencer (master) and the memory slave.
// A transfer happens on every rising ACLK edge where VALID and READY are both high; once raised,
// VALID and its payload stay stable until that edge, and READY may rise or fall at any time.
interface axil_mem_bist_if #(
  parameter int DW = 32
);
  logic [31:0]     AWADDR;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [31:0]     ARADDR;
  logic            ARVALID;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_mem_bist.sv
// AXI4-Lite memory BIST master: writes a seeded pattern to every word, reads it back and
// reports mismatch / error-response counts and the first failing word.
module axil_mem_bist #(
  parameter int          DW        = 32,
  parameter int          NUM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          aborted,
  output logic [15:0]   err_count,
  output logic [15:0]   resp_err_count,
  output logic [31:0]   fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [2:0]    dbg_state,
  axil_mem_bist_if.master m_axil
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e          state, state_n;
  logic [IW-1:0]   idx;
  logic [1:0]      mode_q;
  logic [DW-1:0]   seed_q;
  logic            aw_done, w_done, abort_pend;
  logic [31:0]     awaddr_q, araddr_q;
  logic [DW-1:0]   wdata_q;
  logic            aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic            aw_hs, w_hs, stop, last;
  logic [IW-1:0]   idx_nxt;
  logic [DW-1:0]   rd_exp;

  function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [DW-1:0] s,
                                            input logic [IW-1:0] i);
    logic [DW-1:0] iw;
    iw = DW'(i);
    case (m)
      2'd0:    return s;
      2'd1:    return s + iw;
      2'd2:    return i[0] ? ~s : s;
      default: return ~(s + iw);
    endcase
  endfunction

  function automatic logic [31:0] word_addr(input logic [IW-1:0] i);
    return BASE_ADDR + 32'(i);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign aw_hs   = aw_valid && m_axil.AWREADY;
  assign w_hs    = w_valid && m_axil.WREADY;
  // A latched abort pulse and a live abort level are treated alike at transaction end.
  assign stop    = abort || abort_pend;
  assign last    = (idx == IW'(NUM_WORDS - 1));
  assign idx_nxt = idx + IW'(1);
  assign rd_exp  = pattern(mode_q, seed_q, idx);

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_n = WR_REQ;
      WR_REQ: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        if ((aw_done || m_axil.AWREADY) && (w_done || m_axil.WREADY)) state_n = WR_RESP;
      end
      WR_RESP: begin
        b_ready = 1'b1;
        if (m_axil.BVALID) state_n = stop ? DONE : (last ? RD_REQ : WR_REQ);
      end
      RD_REQ: begin
        ar_valid = 1'b1;
        if (m_axil.ARREADY) state_n = RD_RESP;
      end
      RD_RESP: begin
        r_ready = 1'b1;
        if (m_axil.RVALID) state_n = (stop || last) ? DONE : RD_REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      idx            <= '0;
      mode_q         <= '0;
      seed_q         <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      abort_pend     <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      araddr_q       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      err_count      <= '0;
      resp_err_count <= '0;
      fail_addr      <= '0;
      fail_data      <= '0;
    end else begin
      if (abort && busy) abort_pend <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx            <= '0;
            mode_q         <= mode;
            seed_q         <= seed;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            abort_pend     <= 1'b0;
            awaddr_q       <= word_addr('0);
            wdata_q        <= pattern(mode, seed, '0);
            busy           <= 1'b1;
            done           <= 1'b0;
            aborted        <= 1'b0;
            err_count      <= '0;
            resp_err_count <= '0;
            fail_addr      <= '0;
            fail_data      <= '0;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (m_axil.BVALID) begin
            if (m_axil.BRESP != 2'b00) resp_err_count <= sat_inc(resp_err_count);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (stop) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= 1'b1;
            end else if (last) begin
              idx      <= '0;
              araddr_q <= word_addr('0);
            end else begin
              idx      <= idx_nxt;
              awaddr_q <= word_addr(idx_nxt);
              wdata_q  <= pattern(mode_q, seed_q, idx_nxt);
            end
          end
        end
        RD_RESP: begin
          if (m_axil.RVALID) begin
            if (m_axil.RDATA != rd_exp) begin
              err_count <= sat_inc(err_count);
              if (err_count == 16'd0) begin
                fail_addr <= araddr_q;
                fail_data <= m_axil.RDATA;
              end
            end
            if (m_axil.RRESP != 2'b00) resp_err_count <= sat_inc(resp_err_count);
            if (stop || last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= stop;
            end else begin
              idx      <= idx_nxt;
              araddr_q <= word_addr(idx_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pass      = done && !aborted && (err_count == 16'd0) && (resp_err_count == 16'd0);
  assign dbg_state = state;

  assign m_axil.AWADDR  = awaddr_q;
  assign m_axil.AWVALID = aw_valid;
  assign m_axil.WDATA   = wdata_q;
  assign m_axil.WSTRB   = '1;
  assign m_axil.WVALID  = w_valid;
  assign m_axil.BREADY  = b_ready;
  assign m_axil.ARADDR  = araddr_q;
  assign m_axil.ARVALID = ar_valid;
  assign m_axil.RREADY  = r_ready;

endmodule

// File: tb/tb_axil_mem_bist.sv
// Bench for axil_mem_bist: behavioural 256-word AXI4-Lite memory with fault knobs, expected
// transaction/result queues filled by the driver and drained by a negedge monitor.
module tb_axil_mem_bist;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'd0;
  logic        busy, done, pass, aborted;
  logic [15:0] err_count, resp_err_count;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  dbg_state;

  axil_mem_bist_if #(.DW(32)) bus ();

  axil_mem_bist #(.DW(32), .NUM_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .aborted(aborted), .err_count(err_count),
    .resp_err_count(resp_err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .dbg_state(dbg_state), .m_axil(bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] err;
    logic [15:0] rerr;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic        pass;
    logic        abrt;
  } res_t;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];
  res_t        exp_res_q[$];

  int tests = 0;
  int fails = 0;
  int b_hs_cnt = 0;
  int r_hs_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory slave model ----------------
  logic [31:0] mem [0:255];
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [31:0] aw_addr_q, w_data_q, rdata_r;
  logic [1:0]  rresp_r;
  int          stall_cnt;
  int          cfg_stall = 0;
  int          cfg_flip = -1;
  int          cfg_rresp = -1;

  assign bus.AWREADY = !aw_got && !bvalid_r && (stall_cnt == 0);
  assign bus.WREADY  = !w_got && !bvalid_r;
  assign bus.BVALID  = bvalid_r;
  assign bus.BRESP   = 2'b00;
  assign bus.ARREADY = !rvalid_r;
  assign bus.RVALID  = rvalid_r;
  assign bus.RDATA   = rdata_r;
  assign bus.RRESP   = rresp_r;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; rdata_r <= '0; rresp_r <= '0;
      stall_cnt <= cfg_stall;
    end else begin
      if (bus.AWVALID && stall_cnt != 0) stall_cnt <= stall_cnt - 1;
      if (bus.AWVALID && bus.AWREADY) begin
        aw_got <= 1'b1; aw_addr_q <= bus.AWADDR; stall_cnt <= cfg_stall;
      end
      if (bus.WVALID && bus.WREADY) begin
        w_got <= 1'b1; w_data_q <= bus.WDATA;
      end
      if (aw_got && w_got && !bvalid_r) begin
        mem[aw_addr_q[7:0]] <= (int'(aw_addr_q) == cfg_flip) ? (w_data_q ^ 32'd1) : w_data_q;
        aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b1;
      end
      if (bvalid_r && bus.BREADY) bvalid_r <= 1'b0;
      if (bus.ARVALID && bus.ARREADY) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[bus.ARADDR[7:0]];
        rresp_r  <= (int'(bus.ARADDR) == cfg_rresp) ? 2'b10 : 2'b00;
      end
      if (rvalid_r && bus.RREADY) rvalid_r <= 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        done_prev = 1'b0;
  logic        p_aw_pend = 1'b0, p_w_pend = 1'b0, p_ar_pend = 1'b0;
  logic        p_aw_hs = 1'b0, p_w_hs = 1'b0, p_ar_hs = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(negedge ACLK) begin
    if (ARESET) begin
      done_prev = 1'b0;
      p_aw_pend = 1'b0; p_w_pend = 1'b0; p_ar_pend = 1'b0;
      p_aw_hs = 1'b0; p_w_hs = 1'b0; p_ar_hs = 1'b0;
    end else begin
      if (bus.AWVALID && bus.AWREADY) begin
        check("aw_expected", 32'(exp_aw_q.size() != 0), 32'd1);
        if (exp_aw_q.size() != 0) check("awaddr", bus.AWADDR, exp_aw_q.pop_front());
      end
      if (bus.WVALID && bus.WREADY) begin
        check("w_expected", 32'(exp_w_q.size() != 0), 32'd1);
        if (exp_w_q.size() != 0) check("wdata", bus.WDATA, exp_w_q.pop_front());
        check("wstrb", 32'(bus.WSTRB), 32'hF);
      end
      if (bus.ARVALID && bus.ARREADY) begin
        check("ar_expected", 32'(exp_ar_q.size() != 0), 32'd1);
        if (exp_ar_q.size() != 0) check("araddr", bus.ARADDR, exp_ar_q.pop_front());
      end
      if (bus.BVALID && bus.BREADY) b_hs_cnt++;
      if (bus.RVALID && bus.RREADY) r_hs_cnt++;
      if (p_aw_pend) check("aw_held", {bus.AWVALID, bus.AWADDR[30:0]}, {1'b1, p_awaddr[30:0]});
      if (p_w_pend)  check("w_held", {bus.WVALID, bus.WDATA[30:0]}, {1'b1, p_wdata[30:0]});
      if (p_ar_pend) check("ar_held", {bus.ARVALID, bus.ARADDR[30:0]}, {1'b1, p_araddr[30:0]});
      if (p_aw_hs) check("awvalid_drop", 32'(bus.AWVALID), 32'd0);
      if (p_w_hs)  check("wvalid_drop", 32'(bus.WVALID), 32'd0);
      if (p_ar_hs) check("arvalid_drop", 32'(bus.ARVALID), 32'd0);
      if (bus.ARVALID) check("ar_during_write", 32'({bus.AWVALID, bus.WVALID, bus.BREADY}), 32'd0);
      if (done && !done_prev) begin
        check("res_expected", 32'(exp_res_q.size() != 0), 32'd1);
        if (exp_res_q.size() != 0) begin
          res_t r;
          r = exp_res_q.pop_front();
          check("err_count", 32'(err_count), 32'(r.err));
          check("resp_err_count", 32'(resp_err_count), 32'(r.rerr));
          check("fail_addr", fail_addr, r.faddr);
          check("fail_data", fail_data, r.fdata);
          check("pass", 32'(pass), 32'(r.pass));
          check("aborted", 32'(aborted), 32'(r.abrt));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      done_prev = done;
      p_aw_pend = bus.AWVALID && !bus.AWREADY; p_awaddr = bus.AWADDR;
      p_w_pend  = bus.WVALID && !bus.WREADY;   p_wdata  = bus.WDATA;
      p_ar_pend = bus.ARVALID && !bus.ARREADY; p_araddr = bus.ARADDR;
      p_aw_hs = bus.AWVALID && bus.AWREADY;
      p_w_hs  = bus.WVALID && bus.WREADY;
      p_ar_hs = bus.ARVALID && bus.ARREADY;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] exp_pat(input logic [1:0] m, input logic [31:0] s, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    case (m)
      2'd0:    return s;
      2'd1:    return s + iv;
      2'd2:    return iv[0] ? ~s : s;
      default: return ~(s + iv);
    endcase
  endfunction

  task automatic clear_queues();
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_res_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valids"}, 32'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    clear_queues();
    @(negedge ACLK);
    check_idle_outputs("rst");
    check("rst_pass_aborted", 32'({pass, aborted}), 32'd0);
    check("rst_counts", {err_count, resp_err_count}, 32'd0);
    check("rst_fail_addr", fail_addr, 32'd0);
    check("rst_fail_data", fail_data, 32'd0);
    check("rst_readies", 32'({bus.BREADY, bus.RREADY}), 32'd0);
    check("rst_addr_data", bus.AWADDR | bus.WDATA | bus.ARADDR, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
  endtask

  task automatic push_run(input logic [1:0] m, input logic [31:0] s, input int n_rd, input res_t r);
    for (int i = 0; i < 256; i++) begin
      exp_aw_q.push_back(32'(i));
      exp_w_q.push_back(exp_pat(m, s, i));
    end
    for (int i = 0; i < n_rd; i++) exp_ar_q.push_back(32'(i));
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [31:0] s);
    mode = m; seed = s; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int abort_at, input int budget);
    int n;
    logic sent;
    n = 0; sent = 1'b0;
    while (!done && n < budget) begin
      if (abort_at >= 0 && !sent && bus.ARVALID && bus.ARADDR == 32'(abort_at)) begin
        abort = 1'b1; sent = 1'b1;
      end else begin
        abort = 1'b0;
      end
      @(negedge ACLK);
      n++;
    end
    abort = 1'b0;
    check("done_in_budget", 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic [31:0] s, input int n_rd,
                     input res_t r, input int abort_at, input logic poke_start);
    int b0, r0;
    push_run(m, s, n_rd, r);
    b0 = b_hs_cnt; r0 = r_hs_cnt;
    pulse_start(m, s);
    if (poke_start) begin
      repeat (50) @(negedge ACLK);
      pulse_start(~m, ~s);
    end
    wait_done(abort_at, 20000);
    repeat (3) @(negedge ACLK);
    check({tag, "_b_count"}, 32'(b_hs_cnt - b0), 32'd256);
    check({tag, "_r_count"}, 32'(r_hs_cnt - r0), 32'(n_rd));
    check({tag, "_aw_left"}, 32'(exp_aw_q.size()), 32'd0);
    check({tag, "_w_left"}, 32'(exp_w_q.size()), 32'd0);
    check({tag, "_ar_left"}, 32'(exp_ar_q.size()), 32'd0);
    check({tag, "_res_left"}, 32'(exp_res_q.size()), 32'd0);
    check({tag, "_still_done"}, 32'({done, busy}), 32'b10);
  endtask

  res_t r_pass, r_flip, r_rresp, r_abort;

  initial begin
    r_pass  = '{err: 16'd0, rerr: 16'd0, faddr: 32'd0,  fdata: 32'd0,          pass: 1'b1, abrt: 1'b0};
    r_flip  = '{err: 16'd1, rerr: 16'd0, faddr: 32'h45, fdata: 32'h0000_1044, pass: 1'b0, abrt: 1'b0};
    r_rresp = '{err: 16'd0, rerr: 16'd1, faddr: 32'd0,  fdata: 32'd0,          pass: 1'b0, abrt: 1'b0};
    r_abort = '{err: 16'd0, rerr: 16'd0, faddr: 32'd0,  fdata: 32'd0,          pass: 1'b0, abrt: 1'b1};

    do_reset();
    // mode 0 clean run; a start mid-run with other mode/seed must be ignored
    run("m0", 2'd0, 32'hA5A5_A5A5, 256, r_pass, -1, 1'b1);

    // back-to-back start from DONE, word 0x45 corrupted by the slave
    cfg_flip = 32'h45;
    run("flip", 2'd1, 32'h0000_1000, 256, r_flip, -1, 1'b0);
    cfg_flip = -1;

    // AWREADY stalled 5 cycles per write, WREADY immediate
    cfg_stall = 5;
    do_reset();
    run("stall", 2'd3, 32'h1234_5678, 256, r_pass, -1, 1'b0);
    cfg_stall = 0;
    do_reset();

    // SLVERR read response with correct data
    cfg_rresp = 32'h80;
    run("rresp", 2'd2, 32'h0F0F_0000, 256, r_rresp, -1, 1'b0);
    cfg_rresp = -1;

    // abort during the read of idx 10
    run("abort", 2'd0, 32'h0000_0000, 11, r_abort, 10, 1'b0);

    // reset mid write request, then a fresh full run
    push_run(2'd1, 32'h0, 256, r_pass);
    pulse_start(2'd1, 32'h0);
    begin
      int n;
      n = 0;
      while (!(bus.AWVALID && bus.AWADDR == 32'd3) && n < 200) begin
        @(negedge ACLK);
        n++;
      end
      check("reach_aw3", 32'(bus.AWVALID), 32'd1);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    check_idle_outputs("midrst");
    ARESET = 1'b0;
    clear_queues();
    @(negedge ACLK);
    run("rerun", 2'd1, 32'h0, 256, r_pass, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
